reduccion_segmentada: RTL and testbench
=======================================

Name: reduccion_segmentada

Overview:
- Parametrised, pipelined successor to the team's combinational chained-reduction cell array.
- Reduces an ANCHO-bit operand to one bit using a run-time selectable operator (AND/OR/XOR/XNOR).
- Processes SEG bits per pipeline stage, with a register between stages and a valid/ready handshake at both ends.
- Sits between a producer of packed flag/word data and a consumer needing per-word reduction results at one result per cycle.

Parameters:
- ANCHO, 8, operand width in bits; must be ≥1.
- SEG, 2, cells (bits) combined per pipeline stage; 1 ≤ SEG ≤ ANCHO.
- N_ETAPAS (localparam), ceil(ANCHO/SEG), number of register stages and the latency in cycles.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  ANCHO  operand, sampled on accept.
- modo  input  2  operator, sampled on accept: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- valid_in  input  1  operand/modo valid.
- ready_in  output  1  block can accept this cycle.
- b  output  1  reduction result.
- modo_out  output  2  modo that travelled with the result.
- valid_out  output  1  b/modo_out valid.
- ready_out  input  1  consumer accepts this cycle.
- ocupado  output  1  any stage holds valid data.

Behaviour:
- Reset (async assert, released synchronously by clk): all stage valid bits, b, modo_out, valid_out and ocupado go to 0. ready_in is then 1. Data registers reset to 0.
- Stage k (0..N_ETAPAS-1) combines bits [k*SEG .. min((k+1)*SEG,ANCHO)-1] into a partial result in ascending bit order.
- The last stage may cover fewer than SEG bits; there is no padding effect on the result.
- Partial seed entering stage 0: 1 for AND, 0 for OR/XOR/XNOR.
- XNOR is computed as XOR through the chain, then inverted in the final stage only.
- Each stage carries: partial bit, modo, the unprocessed upper bits of a, and a valid bit.
- Handshake:
  - listo[N_ETAPAS-1] = !valid_out || ready_out.
  - listo[k] = !v[k] || listo[k+1].
  - ready_in = listo[0].
- Stage k loads from upstream when listo[k]. Its valid becomes the upstream valid (valid_in && ready_in for stage 0), so bubbles collapse.
- Stall: while valid_out && !ready_out, b and modo_out hold stable. Stages fill and ready_in deasserts only when every stage is valid. No data is lost or duplicated.
- Latency: operand accepted at edge t appears with valid_out=1 after edge t+N_ETAPAS-1, i.e. N_ETAPAS cycles on the output when unstalled.
- Throughput: one operand per cycle with ready_out held 1.
- Order preserved: FIFO semantics, depth N_ETAPAS.
- ready_in is purely combinational from valid bits and ready_out. There is no combinational path from valid_in to ready_in.
- Simultaneous accept at input and drain at output in the same cycle while full: allowed, throughput is maintained.
- ocupado = OR of all stage valid bits (including the output stage).
- Reset mid-operation: all in-flight results are discarded immediately. The first post-reset accept behaves as from an empty pipe.
- ANCHO=1, SEG=1: single stage, latency 1.

Test Plan:
- ANCHO=8, SEG=2, ready_out=1. Accept a=8'hFF, modo=00 at edge 0 → valid_out=1, b=1, modo_out=00 after edge 3; a=8'hFE → b=0.
- Back-to-back stream, one per cycle:
  - (8'h00,01) → 0
  - (8'h10,01) → 1
  - (8'h07,10) → 1
  - (8'h07,11) → 0
  - Results appear on 4 consecutive cycles, in order, ready_in constantly 1.
- Backpressure: stream 6 operands with ready_out=0 → ready_in drops after 4 accepts, ocupado=1, b stable. Raise ready_out → all 6 results delivered in order, no gaps beyond the handshake.
- Bubbles: valid_in pattern 1,0,1 with ready_out=1 → valid_out pattern 1,0,1, latency 4 each.
- Reset mid-flight: 3 operands in pipe, pulse rst asynchronously between edges → valid_out, ocupado fall immediately, ready_in=1. No stale result appears afterward.
- ANCHO=7, SEG=3 (N_ETAPAS=3): a=7'h7F, modo=00 → b=1 after 3 cycles; a=7'h40, modo=10 → b=1. Checks the short last stage.

Source files
------------

// File: rtl/reduccion_segmentada.sv
// Pipelined one-bit reduction of an ANCHO-bit operand (AND/OR/XOR/XNOR), SEG bits per stage,
// with a valid/ready handshake on both ends and FIFO ordering through the register stages.
module reduccion_segmentada #(
    parameter int ANCHO = 8,
    parameter int SEG   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] a,
    input  logic [1:0]       modo,
    input  logic             valid_in,
    output logic             ready_in,
    output logic             b,
    output logic [1:0]       modo_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             ocupado
);

    localparam int N_ETAPAS = (ANCHO + SEG - 1) / SEG;
    localparam logic [N_ETAPAS-1:0] TODOS = '1;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_t;

    logic [N_ETAPAS-1:0] v;
    logic [N_ETAPAS-1:0] p;
    logic [N_ETAPAS-1:0] listo;
    op_t                 m [N_ETAPAS];

    assign ready_in  = listo[0];
    assign valid_out = v[N_ETAPAS-1];
    assign b         = p[N_ETAPAS-1];
    assign modo_out  = m[N_ETAPAS-1];
    assign ocupado   = |v;

    for (genvar k = 0; k < N_ETAPAS; k++) begin : g_etapa
        localparam int BASE   = k * SEG;
        localparam int CUENTA = (ANCHO - BASE < SEG) ? (ANCHO - BASE) : SEG;

        logic             vi, pi, pc, vr, pr;
        op_t              mi, mr;
        logic [ANCHO-1:0] di, resto;

        // Unrolled form of listo[k] = !v[k] || listo[k+1]: stage k can load unless it and
        // every stage after it is full while the output is stalled.
        assign listo[k] = ready_out || ((v >> k) != (TODOS >> k));

        if (k == 0) begin : g_ent
            assign vi = valid_in && listo[0];
            assign pi = (modo == OP_AND);
            assign mi = op_t'(modo);
            assign di = a;
        end else begin : g_ent
            assign vi = v[k-1];
            assign pi = p[k-1];
            assign mi = m[k-1];
            assign di = g_etapa[k-1].g_dat.dr;
        end

        // Unprocessed bits travel LSB-aligned, so each stage consumes bit 0 upward.
        always_comb begin
            resto = di;
            pc    = pi;
            for (int unsigned j = 0; j < CUENTA; j++) begin
                case (mi)
                    OP_AND:  pc = pc & resto[0];
                    OP_OR:   pc = pc | resto[0];
                    default: pc = pc ^ resto[0];
                endcase
                resto = resto >> 1;
            end
            if (k == N_ETAPAS - 1 && mi == OP_XNOR) begin
                pc = ~pc;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vr <= 1'b0;
                pr <= 1'b0;
                mr <= OP_AND;
            end else if (listo[k]) begin
                vr <= vi;
                pr <= pc;
                mr <= mi;
            end
        end

        if (k < N_ETAPAS - 1) begin : g_dat
            logic [ANCHO-1:0] dr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dr <= '0;
                end else if (listo[k]) begin
                    dr <= resto;
                end
            end
        end

        assign v[k] = vr;
        assign p[k] = pr;
        assign m[k] = mr;
    end

endmodule

// File: tb/tb_reduccion_segmentada.sv
// Bench for reduccion_segmentada: two configurations (8/2 and 7/3), directed and random traffic
// scored against a FIFO reference model computed from whole-word reduction rules.
module tb_reduccion_segmentada;

    localparam int NA = 4;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_a;
    logic [1:0] modo_a, mo_a;
    logic       vin_a, rdyi_a, b_a, vout_a, rdyo_a, ocup_a;

    logic [6:0] a_b;
    logic [1:0] modo_b, mo_b;
    logic       vin_b, rdyi_b, b_b, vout_b, rdyo_b, ocup_b;

    reduccion_segmentada #(.ANCHO(8), .SEG(2)) dut_a (
        .clk(clk), .rst(rst), .a(a_a), .modo(modo_a), .valid_in(vin_a), .ready_in(rdyi_a),
        .b(b_a), .modo_out(mo_a), .valid_out(vout_a), .ready_out(rdyo_a), .ocupado(ocup_a)
    );

    reduccion_segmentada #(.ANCHO(7), .SEG(3)) dut_b (
        .clk(clk), .rst(rst), .a(a_b), .modo(modo_b), .valid_in(vin_b), .ready_in(rdyi_b),
        .b(b_b), .modo_out(mo_b), .valid_out(vout_b), .ready_out(rdyo_b), .ocupado(ocup_b)
    );

    int errores = 0;
    int cuenta  = 0;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        cuenta++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: obtenido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic reducir(input logic [7:0] x, input logic [1:0] m, input int w);
        logic [7:0] mascara;
        logic [7:0] s;
        mascara = 8'((1 << w) - 1);
        s = x & mascara;
        case (m)
            2'b00:   return s == mascara;
            2'b01:   return s != 8'h00;
            2'b10:   return ($countones(s) % 2) == 1;
            default: return ($countones(s) % 2) == 0;
        endcase
    endfunction

    typedef struct {
        logic        r;
        logic [1:0]  m;
        int unsigned acc;
    } elem_t;

    elem_t qa[$];
    elem_t qb[$];
    int unsigned ec = 0;
    logic ve_a, re_a, ve_b, re_b;

    always @(posedge clk) ec <= ec + 1;

    // Output of an item: after edge max(accept + N - 1, departure of the item ahead).
    always @(negedge clk) begin
        if (!rst) begin
            ve_a = (qa.size() > 0) && (ec >= qa[0].acc + NA - 1);
            re_a = !(qa.size() == NA && !rdyo_a);
            comprobar("A_valid_out", vout_a, ve_a);
            comprobar("A_ocupado", ocup_a, qa.size() != 0);
            comprobar("A_ready_in", rdyi_a, re_a);
            if (ve_a) begin
                comprobar("A_b", b_a, qa[0].r);
                comprobar("A_modo_out", mo_a, qa[0].m);
                if (rdyo_a) void'(qa.pop_front());
            end
            if (vin_a && re_a) qa.push_back(elem_t'{reducir(a_a, modo_a, 8), modo_a, ec + 1});

            ve_b = (qb.size() > 0) && (ec >= qb[0].acc + NB - 1);
            re_b = !(qb.size() == NB && !rdyo_b);
            comprobar("B_valid_out", vout_b, ve_b);
            comprobar("B_ocupado", ocup_b, qb.size() != 0);
            comprobar("B_ready_in", rdyi_b, re_b);
            if (ve_b) begin
                comprobar("B_b", b_b, qb[0].r);
                comprobar("B_modo_out", mo_b, qb[0].m);
                if (rdyo_b) void'(qb.pop_front());
            end
            if (vin_b && re_b) qb.push_back(elem_t'{reducir({1'b0, a_b}, modo_b, 7), modo_b, ec + 1});
        end
    end

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enviar_a(input logic [7:0] x, input logic [1:0] m);
        logic ok;
        int   n;
        vin_a = 1'b1; a_a = x; modo_a = m; n = 0;
        do begin
            @(negedge clk);
            ok = rdyi_a;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) comprobar("A_timeout", 32'd0, 32'd1);
        vin_a = 1'b0;
    endtask

    task automatic enviar_b(input logic [6:0] x, input logic [1:0] m);
        logic ok;
        int   n;
        vin_b = 1'b1; a_b = x; modo_b = m; n = 0;
        do begin
            @(negedge clk);
            ok = rdyi_b;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) comprobar("B_timeout", 32'd0, 32'd1);
        vin_b = 1'b0;
    endtask

    task automatic comprobar_reposo(input string tag);
        comprobar({tag, "_A_valid_out"}, vout_a, 1'b0);
        comprobar({tag, "_A_ocupado"}, ocup_a, 1'b0);
        comprobar({tag, "_A_ready_in"}, rdyi_a, 1'b1);
        comprobar({tag, "_B_valid_out"}, vout_b, 1'b0);
        comprobar({tag, "_B_ocupado"}, ocup_b, 1'b0);
        comprobar({tag, "_B_ready_in"}, rdyi_b, 1'b1);
    endtask

    initial begin
        vin_a = 1'b0; a_a = '0; modo_a = '0; rdyo_a = 1'b1;
        vin_b = 1'b0; a_b = '0; modo_b = '0; rdyo_b = 1'b1;

        #1 rst = 1'b1;
        #1;
        comprobar_reposo("reset");
        comprobar("reset_A_b", b_a, 1'b0);
        comprobar("reset_A_modo_out", mo_a, 2'b00);
        comprobar("reset_B_b", b_b, 1'b0);
        comprobar("reset_B_modo_out", mo_b, 2'b00);
        ciclos(2);
        rst = 1'b0;

        // latency and basic AND
        enviar_a(8'hFF, 2'b00);
        enviar_a(8'hFE, 2'b00);
        ciclos(6);

        // back-to-back stream
        enviar_a(8'h00, 2'b01);
        enviar_a(8'h10, 2'b01);
        enviar_a(8'h07, 2'b10);
        enviar_a(8'h07, 2'b11);
        ciclos(6);

        // backpressure: output stalled while six operands are offered
        rdyo_a = 1'b0;
        fork
            for (int i = 0; i < 6; i++) enviar_a(8'(i * 37 + 3), 2'(i % 4));
            begin
                ciclos(8);
                #2 rdyo_a = 1'b1;
            end
        join
        ciclos(8);

        // bubbles
        enviar_a(8'hA5, 2'b10);
        ciclos(1);
        enviar_a(8'h5A, 2'b11);
        ciclos(6);

        // reset with three operands in flight, the oldest already on the output
        enviar_a(8'hFF, 2'b00);
        enviar_a(8'h01, 2'b01);
        enviar_a(8'h03, 2'b10);
        ciclos(1);
        comprobar("pre_reset_A_valid_out", vout_a, 1'b1);
        #1 rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        comprobar_reposo("mid_reset");
        #1 rst = 1'b0;
        ciclos(6);
        enviar_a(8'h80, 2'b01);
        ciclos(6);

        // short last stage on the 7/3 configuration
        enviar_b(7'h7F, 2'b00);
        enviar_b(7'h40, 2'b10);
        enviar_b(7'h3F, 2'b00);
        enviar_b(7'h41, 2'b11);
        ciclos(6);

        // randomized traffic on both instances
        repeat (400) begin
            vin_a  = 1'($urandom_range(0, 1));
            a_a    = 8'($urandom);
            modo_a = 2'($urandom);
            rdyo_a = ($urandom_range(0, 3) != 0);
            vin_b  = 1'($urandom_range(0, 1));
            a_b    = 7'($urandom);
            modo_b = 2'($urandom);
            rdyo_b = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        vin_a = 1'b0; rdyo_a = 1'b1;
        vin_b = 1'b0; rdyo_b = 1'b1;
        ciclos(10);
        comprobar("A_drenado", qa.size(), 32'd0);
        comprobar("B_drenado", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errores, cuenta);
        $finish;
    end

endmodule
